// File: rtl/div_sequencer.sv
`default_nettype none
// ==========================================================================
// div_sequencer : hands one divide to an iterative divider per accepted start,
// with a divide-by-zero bypass and a Done timeout.       Rev 1.0
// ==========================================================================
module div_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        div_load,
  output logic [15:0] div_a,
  output logic [15:0] div_b,
  output logic        div_reset,
  input  logic        div_done,
  input  logic [15:0] div_q,
  input  logic [15:0] div_r,
  output logic        busy,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        result_valid,
  output logic        div_by_zero,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    ZERO  = 3'd5,
    ABORT = 3'd6
  } state_t;

  localparam logic [17:0] CNT_LAST = 18'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [17:0] cnt_q;
  logic [17:0] cnt_d;
  logic        cnt_last;
  logic        div_load_q, div_reset_q, valid_q, dbz_q, to_q;
  logic [15:0] div_a_q, div_b_q, result_q, remainder_q;

  assign cnt_d    = cnt_q + 18'd1;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_load_q  <= 1'b0;
      div_reset_q <= 1'b0;
      valid_q     <= 1'b0;
      dbz_q       <= 1'b0;
      to_q        <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      div_load_q  <= 1'b0;
      div_reset_q <= 1'b0;
      valid_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            div_a_q <= dividend;
            div_b_q <= divisor;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            if (divisor == 16'd0) begin
              state_q <= ZERO;
            end else begin
              state_q    <= LOAD;
              div_load_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= ARM;
        end
        // Done is still high from the previous divide until the new load lands.
        ARM: begin
          if (!div_done) begin
            cnt_q   <= cnt_d;
            state_q <= WAIT;
          end else if (cnt_last) begin
            state_q     <= ABORT;
            result_q    <= 16'hFFFF;
            remainder_q <= 16'h0000;
            to_q        <= 1'b1;
            div_reset_q <= 1'b1;
            valid_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT: begin
          if (div_done) begin
            result_q    <= div_q;
            remainder_q <= div_r;
            valid_q     <= 1'b1;
            state_q     <= WRITE;
          end else if (cnt_last) begin
            state_q     <= ABORT;
            result_q    <= 16'hFFFF;
            remainder_q <= 16'h0000;
            to_q        <= 1'b1;
            div_reset_q <= 1'b1;
            valid_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WRITE: state_q <= IDLE;
        ZERO: begin
          result_q    <= 16'hFFFF;
          remainder_q <= div_a_q;
          dbz_q       <= 1'b1;
          valid_q     <= 1'b1;
          state_q     <= IDLE;
        end
        ABORT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign div_load     = div_load_q;
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign div_reset    = div_reset_q | ~rst;
  assign result       = result_q;
  assign remainder    = remainder_q;
  assign result_valid = valid_q;
  assign div_by_zero  = dbz_q;
  assign timeout      = to_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// tb_div_sequencer : randomized bench for div_sequencer against an iterative
// divider model, plus a second instance with a stuck-Done stub divider.
module tb_div_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic [15:0] dividend, divisor, dividend2, divisor2;
  logic        div_load, div_reset, div_done, busy, result_valid, div_by_zero, timeout;
  logic [15:0] div_a, div_b, div_q, div_r, result, remainder;
  logic        div_load2, div_reset2, busy2, result_valid2, div_by_zero2, timeout2;
  logic [15:0] div_a2, div_b2, result2, remainder2;
  logic        stub_done = 1'b1;
  logic [15:0] stub_zero = 16'h0000;

  int errors = 0;
  int checks = 0;

  // Behavioural divider: Done drops on load and rises m_lat edges later with a/b, a%b.
  int          m_lat  = 4;
  int          m_cnt  = 0;
  logic        m_done = 1'b1;
  logic [15:0] m_a = 16'd0, m_b = 16'd1, m_q = 16'd0, m_r = 16'd0;
  assign div_done = m_done;
  assign div_q    = m_q;
  assign div_r    = m_r;

  always @(posedge clk) begin
    if (div_reset) begin
      m_cnt <= 0; m_done <= 1'b1;
    end else if (div_load) begin
      m_cnt <= m_lat; m_done <= 1'b0; m_a <= div_a; m_b <= div_b;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0; m_done <= 1'b1;
      m_q    <= (m_b != 16'd0) ? m_a / m_b : 16'hFFFF;
      m_r    <= (m_b != 16'd0) ? m_a % m_b : m_a;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  div_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .div_load(div_load), .div_a(div_a), .div_b(div_b), .div_reset(div_reset),
    .div_done(div_done), .div_q(div_q), .div_r(div_r), .busy(busy),
    .result(result), .remainder(remainder), .result_valid(result_valid),
    .div_by_zero(div_by_zero), .timeout(timeout)
  );

  div_sequencer #(.TIMEOUT_CYCLES(16)) u_to (
    .clk(clk), .rst(rst), .start(start2), .dividend(dividend2), .divisor(divisor2),
    .div_load(div_load2), .div_a(div_a2), .div_b(div_b2), .div_reset(div_reset2),
    .div_done(stub_done), .div_q(stub_zero), .div_r(stub_zero), .busy(busy2),
    .result(result2), .remainder(remainder2), .result_valid(result_valid2),
    .div_by_zero(div_by_zero2), .timeout(timeout2)
  );

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    dividend = 16'd0; divisor = 16'd0; dividend2 = 16'd0; divisor2 = 16'd0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, div_load, result_valid, div_by_zero, timeout} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, div_load, result_valid, div_by_zero, timeout}); end
    checks++; if ({result, remainder, div_a, div_b} !== 64'd0)
      begin errors++; $display("FAIL reset_data: got %h want 0", {result, remainder, div_a, div_b}); end
    checks++; if (div_reset !== 1'b1)
      begin errors++; $display("FAIL reset_div_reset: got %b want 1", div_reset); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (div_reset !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_release: div_reset=%b busy=%b want 0 0", div_reset, busy); end
  endtask

  // One operation from IDLE; expectations come from plain arithmetic and the latency rules.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int lat, input string tag);
    logic [15:0] exp_q, exp_r, got_q, got_r;
    logic        exp_z, got_z, got_t;
    int          exp_k, k_valid, loads, valids;
    bit          unstable, idle_after;
    exp_z = (b == 16'd0);
    exp_q = exp_z ? 16'hFFFF : a / b;
    exp_r = exp_z ? a : a % b;
    // zero: valid one edge after the ZERO cycle; divide: model raises Done lat+1
    // edges after the start edge, WAIT samples it one edge later.
    exp_k = exp_z ? 1 : lat + 2;
    k_valid = -1; loads = 0; valids = 0; unstable = 0; idle_after = 0;
    got_q = 16'd0; got_r = 16'd0; got_z = 1'b0; got_t = 1'b0;
    m_lat = lat; dividend = a; divisor = b; start = 1'b1;
    for (int k = 0; k <= exp_k + 1; k++) begin
      @(negedge clk);
      if (div_load) loads++;
      if (result_valid) begin
        valids++;
        if (k_valid < 0) begin
          k_valid = k; got_q = result; got_r = remainder; got_z = div_by_zero; got_t = timeout;
        end
      end
      if (k <= exp_k && (div_a !== a || div_b !== b)) unstable = 1;
      if (k == exp_k + 1) idle_after = !busy && (result === exp_q) && (remainder === exp_r);
      if (k == 0) begin start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom); end
    end
    checks++; if (k_valid !== exp_k)
      begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, k_valid, exp_k); end
    checks++; if (valids !== 1)
      begin errors++; $display("FAIL %s valid_pulses: got %0d want 1", tag, valids); end
    checks++; if (loads !== (exp_z ? 0 : 1))
      begin errors++; $display("FAIL %s div_load_pulses: got %0d want %0d", tag, loads, exp_z ? 0 : 1); end
    checks++; if (got_q !== exp_q)
      begin errors++; $display("FAIL %s result: got %h want %h", tag, got_q, exp_q); end
    checks++; if (got_r !== exp_r)
      begin errors++; $display("FAIL %s remainder: got %h want %h", tag, got_r, exp_r); end
    checks++; if (got_z !== exp_z || got_t !== 1'b0)
      begin errors++; $display("FAIL %s flags: got dbz=%b to=%b want dbz=%b to=0", tag, got_z, got_t, exp_z); end
    checks++; if (unstable)
      begin errors++; $display("FAIL %s operand_hold: got unstable div_a/div_b want %h/%h", tag, a, b); end
    checks++; if (!idle_after)
      begin errors++; $display("FAIL %s idle_after: got busy=%b result=%h want idle holding %h", tag, busy, result, exp_q); end
  endtask

  task automatic test_normal();
    run_op(16'd100, 16'd7, 5, "div_100_7");
  endtask

  task automatic test_zero();
    run_op(16'h1234, 16'd0, 5, "div_by_zero");
  endtask

  task automatic test_small();
    run_op(16'd5, 16'd9, 3, "div_5_9");
    run_op(16'd9, 16'd9, 4, "div_9_9");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(a, b, int'($urandom_range(1, 20)), "random");
    end
  endtask

  task automatic test_start_held();
    int loads, valids, bad_accept, bad_val, late, extra_loads;
    bit prev_busy;
    logic [15:0] lq, lr;
    loads = 0; valids = 0; bad_accept = 0; bad_val = 0; late = 0; extra_loads = 0;
    lq = 16'd0; lr = 16'd0;
    m_lat = 40; dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    prev_busy = busy;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (div_load) begin loads++; if (prev_busy) bad_accept++; end
      if (result_valid) begin valids++; if (result !== 16'd333 || remainder !== 16'd1) bad_val++; end
      prev_busy = busy;
    end
    start = 1'b0;
    checks++; if (valids !== 1)
      begin errors++; $display("FAIL held_valids: got %0d want 1", valids); end
    checks++; if (bad_val !== 0)
      begin errors++; $display("FAIL held_value: got %0d wrong results want 333 rem 1", bad_val); end
    checks++; if (bad_accept !== 0)
      begin errors++; $display("FAIL held_accept_busy: got %0d loads while busy want 0", bad_accept); end
    checks++; if (loads !== 2)
      begin errors++; $display("FAIL held_loads: got %0d want 2", loads); end
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (div_load) extra_loads++;
      if (result_valid) begin late++; lq = result; lr = remainder; end
    end
    checks++; if (late !== 1 || lq !== 16'd333 || lr !== 16'd1)
      begin errors++; $display("FAIL held_drain: got %0d pulses %0d rem %0d want 1 pulse 333 rem 1", late, lq, lr); end
    checks++; if (extra_loads !== 0 || busy !== 1'b0)
      begin errors++; $display("FAIL held_no_queue: got loads=%0d busy=%b want 0 0", extra_loads, busy); end
  endtask

  task automatic test_reset_mid();
    int valids, loads;
    valids = 0; loads = 0;
    m_lat = 30; dividend = 16'd4000; divisor = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1)
      begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, div_load, result_valid, div_by_zero, timeout} !== 5'b0)
      begin errors++; $display("FAIL mid_reset_ctrl: got %b want 00000", {busy, div_load, result_valid, div_by_zero, timeout}); end
    checks++; if ({result, remainder, div_a, div_b} !== 64'd0)
      begin errors++; $display("FAIL mid_reset_data: got %h want 0", {result, remainder, div_a, div_b}); end
    checks++; if (div_reset !== 1'b1)
      begin errors++; $display("FAIL mid_reset_div_reset: got %b want 1", div_reset); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) valids++;
      if (div_load) loads++;
    end
    checks++; if (valids !== 0 || loads !== 0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_abandon: got valids=%0d loads=%0d busy=%b want 0 0 0", valids, loads, busy); end
  endtask

  task automatic test_timeout();
    int kv, resets, loads;
    logic [15:0] gq, gr;
    logic gt, gz;
    kv = -1; resets = 0; loads = 0; gq = 16'd0; gr = 16'd0; gt = 1'b0; gz = 1'b0;
    dividend2 = 16'd50; divisor2 = 16'd5; start2 = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      if (div_load2) loads++;
      if (div_reset2) resets++;
      if (result_valid2 && kv < 0) begin
        kv = k; gq = result2; gr = remainder2; gt = timeout2; gz = div_by_zero2;
      end
      if (k == 0) start2 = 1'b0;
    end
    checks++; if (kv < 1 || kv > 18)
      begin errors++; $display("FAIL to_latency: got %0d want 1..18", kv); end
    checks++; if (gq !== 16'hFFFF || gr !== 16'h0000)
      begin errors++; $display("FAIL to_values: got %h/%h want ffff/0000", gq, gr); end
    checks++; if (gt !== 1'b1 || gz !== 1'b0)
      begin errors++; $display("FAIL to_flags: got to=%b dbz=%b want 1 0", gt, gz); end
    checks++; if (resets !== 1 || loads !== 1)
      begin errors++; $display("FAIL to_pulses: got resets=%0d loads=%0d want 1 1", resets, loads); end
    checks++; if (busy2 !== 1'b0 || timeout2 !== 1'b1 || div_a2 !== 16'd50 || div_b2 !== 16'd5)
      begin errors++; $display("FAIL to_after: got busy=%b to=%b a=%0d b=%0d want 0 1 50 5", busy2, timeout2, div_a2, div_b2); end
    dividend2 = 16'h0BEE; divisor2 = 16'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    checks++; if (result_valid2 !== 1'b1 || timeout2 !== 1'b0 || div_by_zero2 !== 1'b1)
      begin errors++; $display("FAIL to_clear: got valid=%b to=%b dbz=%b want 1 0 1", result_valid2, timeout2, div_by_zero2); end
    checks++; if (result2 !== 16'hFFFF || remainder2 !== 16'h0BEE)
      begin errors++; $display("FAIL to_zero_values: got %h/%h want ffff/0bee", result2, remainder2); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_small();
    test_random();
    test_start_held();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 200000, maximum cycles spent waiting on the divider before abort; the counter is 18 bits wide.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
REQ-004 start  in  1  divide request from the controller, sampled only in IDLE.
REQ-005 dividend  in  16  numerator (ACC value).
REQ-006 divisor  in  16  denominator (MDR value).
REQ-007 div_load  out  1  Load strobe to the iterative divider.
REQ-008 div_a  out  16  registered dividend to the divider.
REQ-009 div_b  out  16  registered divisor to the divider.
REQ-010 div_reset  out  1  active-high Reset to the divider.
REQ-011 div_done  in  1  Done from the divider.
REQ-012 div_q  in  16  quotient from the divider.
REQ-013 div_r  in  16  remainder from the divider.
REQ-014 busy  out  1  stall to the controller; high in every state except IDLE.
REQ-015 result  out  16  quotient, held until the next completion.
REQ-016 remainder  out  16  remainder, held until the next completion.
REQ-017 result_valid  out  1  one-cycle pulse that drives ACC load.
REQ-018 div_by_zero  out  1  sticky flag, cleared on the next accepted start.
REQ-019 timeout  out  1  sticky flag, cleared on the next accepted start.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, LOAD, ARM, WAIT, WRITE, ZERO, ABORT.
REQ-021 IDLE with start=1: latch dividend into div_a and divisor into div_b, clear both flags, then go to ZERO if divisor==0, otherwise go to LOAD.
REQ-022 LOAD: div_load=1 for exactly one cycle; the timeout counter clears; next state is ARM.
REQ-023 ARM: wait for div_done==0, because Done stays high from the previous operation; go to WAIT when div_done==0 is sampled.
REQ-024 WAIT: on div_done==1, capture div_q into result and div_r into remainder; next state is WRITE.
REQ-025 WRITE: result_valid=1 for one cycle; next state is IDLE.
REQ-026 ZERO: the divider SHALL NOT be loaded; result=16'hFFFF, remainder=dividend, div_by_zero=1, result_valid=1 for one cycle; next state is IDLE.
REQ-027 The timeout counter SHALL increment each cycle in ARM and WAIT; on reaching TIMEOUT_CYCLES-1, go to ABORT.
REQ-028 ABORT: result=16'hFFFF, remainder=0, timeout=1, div_reset=1 and result_valid=1 for one cycle; next state is IDLE.
REQ-029 Latency SHALL be: ZERO result_valid 2 cycles after the start edge; normal path result_valid 1 cycle after the div_done==1 sample in WAIT.
REQ-030 A start asserted outside IDLE SHALL be ignored and not queued.
REQ-031 div_load SHALL be asserted exactly once per accepted non-zero divide.
REQ-032 div_a and div_b SHALL stay stable from LOAD until the return to IDLE.
REQ-033 Unsigned arithmetic only; no width extension or truncation of div_q or div_r.
REQ-034 An illegal or unreachable state SHALL return to IDLE on the next edge with busy=0.

Reset
REQ-035 When rst==0 at a clock edge: state=IDLE, busy=0, div_load=0, result_valid=0, result=0, remainder=0, div_a=0, div_b=0, div_by_zero=0, timeout=0, counter=0.
REQ-036 div_reset SHALL equal 1 during every cycle in which rst==0, and during ABORT.
REQ-037 Reset mid-operation SHALL abandon the divide with no result_valid pulse, and the divider is reset.

Verification
REQ-038 100/7 with a real divider: one div_load pulse, then result=14, remainder=2, a single result_valid pulse, busy low the cycle after.
REQ-039 0x1234/0: no div_load, result=0xFFFF, remainder=0x1234, div_by_zero=1, result_valid 2 cycles after start.
REQ-040 5/9: result=0, remainder=5; then 9/9: result=1, remainder=0, with div_by_zero still 0.
REQ-041 start held high for 50 cycles during a 1000/3 divide: exactly one result (333, 1) is produced while start is high; a new op is accepted only in IDLE.
REQ-042 rst=0 asserted while in WAIT: the next cycle shows busy=0, all outputs 0, div_reset=1, and no result_valid.
REQ-043 TIMEOUT_CYCLES=16 with a stub divider whose Done never falls: ABORT is reached within 18 cycles of LOAD, timeout=1, result=0xFFFF, with one div_reset pulse.
